rgb2raw: RTL and testbench
==========================

Name: rgb2raw

Overview:
- Bayer mosaic encoder: converts a 24-bit RGB pixel stream into an 8-bit Bayer RAW stream. It is the inverse of the RAW2RGB demosaic stage.
- Used as a sensor emulator, so the demosaic path and DDR3/TFT pipeline can be exercised without the OV5640.
- Tracks pixel/line position from stream markers, selects one colour per pixel by Bayer phase, and measures frame geometry.

Parameters:
- CNT_W, 12, width of column/line counters and geometry outputs.
- DEF_PATTERN, 2'd0, Bayer pattern used after reset until the first frame latches Pattern. Encoding: 0=RGGB, 1=GRBG, 2=GBRG, 3=BGGR.

Ports:
- Clk  in  1  pixel clock.
- Rst_n  in  1  asynchronous active-low reset.
- Din_Valid  in  1  input pixel valid this cycle.
- Din_Sof  in  1  first pixel of frame; qualified by Din_Valid.
- Din_Eol  in  1  last pixel of line; qualified by Din_Valid.
- RED  in  8  red component.
- GREEN  in  8  green component.
- BLUE  in  8  blue component.
- Pattern  in  2  Bayer pattern select; sampled only on an accepted Sof.
- RAW_Data  out  8  Bayer sample.
- Dout_Valid  out  1  RAW_Data valid.
- Dout_Sof  out  1  aligned Sof.
- Dout_Eol  out  1  aligned Eol.
- Line_Len  out  CNT_W  pixels in first line of current frame.
- Frame_Lines  out  CNT_W  lines in last completed frame.
- Len_Err  out  1  sticky: a line length differed from Line_Len.

Behaviour:
- Reset: all outputs 0; state WAIT_SOF; x=y=0; active pattern = DEF_PATTERN.
- States:
  - WAIT_SOF: pixels with Valid=1 and Sof=0 are dropped (no output). Valid and Sof go to ACTIVE and are processed as pixel (0,0).
  - ACTIVE: every Valid pixel is processed. Valid and Sof restarts the frame (see below). No exit to WAIT_SOF except reset.
- On accepted Sof (either state):
  - Latch Pattern.
  - Clear Len_Err.
  - If the previous frame had y>0, load Frame_Lines=y. An aborted frame still reports completed lines; y=0 leaves Frame_Lines unchanged.
  - Set x=0, y=0 for this pixel.
- Phase and mux:
  - px = x[0]^pat[0]; py = y[0]^pat[1].
  - (py,px)=(0,0) selects RED; (0,1) or (1,0) selects GREEN; (1,1) selects BLUE.
- Latency: exactly 1 cycle.
  - RAW_Data, Dout_Valid, Dout_Sof and Dout_Eol are registered from cycle-n inputs.
  - Dout_Valid=0 when no pixel is processed; RAW_Data then holds its last value.
- Counters:
  - Valid without Eol: x++, saturating at 2^CNT_W-1.
  - Valid with Eol: pixel processed at current x, then len=x+1 (saturated). Then x=0 and y++ (saturating).
  - First Eol of a frame (y==0): Line_Len=len.
  - Later Eol with len!=Line_Len: Len_Err=1, held until next accepted Sof.
- Simultaneous Sof and Eol on one pixel (1-pixel line): pixel at (0,0); Line_Len=1; y becomes 1.
- Gaps: Din_Valid=0 cycles advance nothing; the pattern phase depends only on counted pixels.
- Pattern changes mid-frame are ignored until the next Sof.
- Reset mid-frame: immediate return to reset values; the next frame requires Sof.

Decomposition:
- Shared package holds:
  - Bayer pattern codes PAT_RGGB/GRBG/GBRG/BGGR (2-bit).
  - State encoding ST_WAIT_SOF/ST_ACTIVE.
  - Colour select codes SEL_R/G/B.
- Optional sub-module bayer_phase_sel: pure combinational (x[0], y[0], pattern) -> colour select. It is shared with test-pattern logic.
- Counters, FSM and output register stay in rgb2raw.

Test Plan:
- RGGB frame: Pattern=0, 4x2 frame, R=8'h11, G=8'h22, B=8'h33 constant.
  - RAW sequence 11,22,11,22 / 22,33,22,33.
  - Line_Len=4; Frame_Lines=2 after the next Sof; Len_Err=0; each output 1 cycle after input.
- All patterns: repeat the 2x2 frame with Pattern=1,2,3.
  - First lines 22,11 / 22,33 / 33,22.
  - Second lines 33,22 / 11,22 / 22,11.
  - Changing Pattern mid-frame has no effect until Sof.
- Pre-Sof and gaps:
  - 3 Valid pixels before any Sof -> Dout_Valid stays 0.
  - Random Valid=0 gaps inside lines -> RAW sequence identical to the gapless case.
- Length error: lines of 4,4,3 pixels -> Len_Err rises 1 cycle after the 3-pixel line's Eol, stays 1, clears on the next Sof.
- Abort and reset:
  - Sof after 1.5 lines -> Frame_Lines=1; new frame restarts at R phase (RGGB).
  - Rst_n low mid-line -> all outputs 0 asynchronously; Pattern reverts to DEF_PATTERN.
- 1-pixel lines: each pixel Sof/Eol=1 on the first line, Eol=1 on the rest, 3 lines -> RAW 11,22,11; Line_Len=1; Len_Err=0.

Source files
------------

// File: rtl/rgb2raw_pkg.sv
// Shared definitions for the RGB-to-Bayer encoder: pattern codes, control states
// and per-pixel colour select codes.
package rgb2raw_pkg;

    localparam logic [1:0] PAT_RGGB = 2'd0;
    localparam logic [1:0] PAT_GRBG = 2'd1;
    localparam logic [1:0] PAT_GBRG = 2'd2;
    localparam logic [1:0] PAT_BGGR = 2'd3;

    typedef enum logic {
        ST_WAIT_SOF = 1'b0,
        ST_ACTIVE   = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        SEL_R = 2'd0,
        SEL_G = 2'd1,
        SEL_B = 2'd2
    } sel_e;

endpackage

// File: rtl/rgb2raw_if.sv
// Pixel stream bundle: RGB input side, Bayer RAW output side and frame geometry status.
interface rgb2raw_if #(
    parameter int unsigned CNT_W = 12
);
    logic             Din_Valid;
    logic             Din_Sof;
    logic             Din_Eol;
    logic [7:0]       RED;
    logic [7:0]       GREEN;
    logic [7:0]       BLUE;
    logic [1:0]       Pattern;
    logic [7:0]       RAW_Data;
    logic             Dout_Valid;
    logic             Dout_Sof;
    logic             Dout_Eol;
    logic [CNT_W-1:0] Line_Len;
    logic [CNT_W-1:0] Frame_Lines;
    logic             Len_Err;

    modport master (
        output Din_Valid, Din_Sof, Din_Eol, RED, GREEN, BLUE, Pattern,
        input  RAW_Data, Dout_Valid, Dout_Sof, Dout_Eol, Line_Len, Frame_Lines, Len_Err
    );

    modport slave (
        input  Din_Valid, Din_Sof, Din_Eol, RED, GREEN, BLUE, Pattern,
        output RAW_Data, Dout_Valid, Dout_Sof, Dout_Eol, Line_Len, Frame_Lines, Len_Err
    );
endinterface

// File: rtl/rgb2raw_bayer_phase_sel.sv
// Bayer phase decoder: picks the colour present at a pixel from coordinate parity
// and the 2-bit pattern code.
module rgb2raw_bayer_phase_sel
    import rgb2raw_pkg::*;
(
    input  logic       x0_i,
    input  logic       y0_i,
    input  logic [1:0] pat_i,
    output sel_e       sel_o
);
    logic px;
    logic py;

    always_comb begin
        px = x0_i ^ pat_i[0];
        py = y0_i ^ pat_i[1];
        unique case ({py, px})
            2'b00:   sel_o = SEL_R;
            2'b11:   sel_o = SEL_B;
            default: sel_o = SEL_G;
        endcase
    end
endmodule

// File: rtl/rgb2raw.sv
// RGB to Bayer RAW mosaic encoder: tracks pixel position from Sof/Eol markers, emits one
// colour per pixel with one cycle of latency and measures frame geometry.
module rgb2raw
    import rgb2raw_pkg::*;
#(
    parameter int unsigned CNT_W       = 12,
    parameter logic [1:0]  DEF_PATTERN = 2'd0
) (
    input  logic       Clk,
    input  logic       Rst_n,
    rgb2raw_if.slave   bus
);
    state_e           state_q, state_d;
    logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
    logic [CNT_W-1:0] line_len_q, line_len_d, frame_lines_q, frame_lines_d;
    logic [1:0]       pat_q, pat_d;
    logic             len_err_q, len_err_d;
    logic [7:0]       raw_q, raw_d;
    logic             dv_q, dv_d, dsof_q, dsof_d, deol_q, deol_d;

    logic             accept_sof;
    logic             process;
    logic [CNT_W-1:0] cur_x, cur_y, x_inc, y_inc;
    logic [1:0]       cur_pat;
    sel_e             sel;

    // An accepted Sof forces this pixel to (0,0) with the freshly sampled pattern.
    always_comb begin
        accept_sof = bus.Din_Valid && bus.Din_Sof;
        process    = bus.Din_Valid && (state_q == ST_ACTIVE || bus.Din_Sof);
        cur_x      = accept_sof ? '0 : x_q;
        cur_y      = accept_sof ? '0 : y_q;
        cur_pat    = accept_sof ? bus.Pattern : pat_q;
        x_inc      = (cur_x == '1) ? cur_x : cur_x + CNT_W'(1);
        y_inc      = (cur_y == '1) ? cur_y : cur_y + CNT_W'(1);
    end

    rgb2raw_bayer_phase_sel u_phase_sel (
        .x0_i  (cur_x[0]),
        .y0_i  (cur_y[0]),
        .pat_i (cur_pat),
        .sel_o (sel)
    );

    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        pat_d         = pat_q;
        line_len_d    = line_len_q;
        frame_lines_d = frame_lines_q;
        len_err_d     = len_err_q;
        raw_d         = raw_q;
        dv_d          = process;
        dsof_d        = process && bus.Din_Sof;
        deol_d        = process && bus.Din_Eol;

        if (accept_sof) begin
            state_d   = ST_ACTIVE;
            pat_d     = bus.Pattern;
            len_err_d = 1'b0;
            if (y_q != '0) frame_lines_d = y_q;
        end

        if (process) begin
            unique case (sel)
                SEL_R:   raw_d = bus.RED;
                SEL_G:   raw_d = bus.GREEN;
                SEL_B:   raw_d = bus.BLUE;
                default: raw_d = raw_q;
            endcase
            if (bus.Din_Eol) begin
                x_d = '0;
                y_d = y_inc;
                // x_inc is the saturated length of the line that just ended.
                if (cur_y == '0) begin
                    line_len_d = x_inc;
                end else if (x_inc != line_len_q) begin
                    len_err_d = 1'b1;
                end
            end else begin
                x_d = x_inc;
                y_d = cur_y;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q       <= ST_WAIT_SOF;
            x_q           <= '0;
            y_q           <= '0;
            pat_q         <= DEF_PATTERN;
            line_len_q    <= '0;
            frame_lines_q <= '0;
            len_err_q     <= 1'b0;
            raw_q         <= '0;
            dv_q          <= 1'b0;
            dsof_q        <= 1'b0;
            deol_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            pat_q         <= pat_d;
            line_len_q    <= line_len_d;
            frame_lines_q <= frame_lines_d;
            len_err_q     <= len_err_d;
            raw_q         <= raw_d;
            dv_q          <= dv_d;
            dsof_q        <= dsof_d;
            deol_q        <= deol_d;
        end
    end

    assign bus.RAW_Data    = raw_q;
    assign bus.Dout_Valid  = dv_q;
    assign bus.Dout_Sof    = dsof_q;
    assign bus.Dout_Eol    = deol_q;
    assign bus.Line_Len    = line_len_q;
    assign bus.Frame_Lines = frame_lines_q;
    assign bus.Len_Err     = len_err_q;
endmodule

// File: tb/tb_rgb2raw.sv
// Directed bench for rgb2raw: expected RAW samples are queued as pixels are driven and
// popped when the encoder presents them one cycle later.
module tb_rgb2raw;
    logic Clk;
    logic Rst_n;

    rgb2raw_if #(.CNT_W(12)) bus ();

    rgb2raw #(.CNT_W(12), .DEF_PATTERN(2'd0)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0] raw;
        logic       sof;
        logic       eol;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle; ev says whether this input must produce an output next cycle.
    task automatic step(input logic v, input logic s, input logic e, input logic ev,
                        input logic [7:0] eraw);
        exp_t got;
        bus.Din_Valid = v;
        bus.Din_Sof   = s;
        bus.Din_Eol   = e;
        if (ev) sb.push_back('{raw: eraw, sof: s, eol: e});
        @(posedge Clk);
        #1;
        chk("dout_valid", 32'(bus.Dout_Valid), 32'(ev));
        if (bus.Dout_Valid) begin
            chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                got = sb.pop_front();
                chk("raw_data", 32'(bus.RAW_Data), 32'(got.raw));
                chk("dout_sof", 32'(bus.Dout_Sof), 32'(got.sof));
                chk("dout_eol", 32'(bus.Dout_Eol), 32'(got.eol));
            end
        end
    endtask

    task automatic pix(input logic s, input logic e, input logic [7:0] eraw);
        step(1'b1, s, e, 1'b1, eraw);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_raw"}, 32'(bus.RAW_Data), 32'd0);
        chk({tag, "_dv"}, 32'(bus.Dout_Valid), 32'd0);
        chk({tag, "_sof"}, 32'(bus.Dout_Sof), 32'd0);
        chk({tag, "_eol"}, 32'(bus.Dout_Eol), 32'd0);
        chk({tag, "_line_len"}, 32'(bus.Line_Len), 32'd0);
        chk({tag, "_frame_lines"}, 32'(bus.Frame_Lines), 32'd0);
        chk({tag, "_len_err"}, 32'(bus.Len_Err), 32'd0);
    endtask

    logic [7:0] rggb_exp [8];

    initial begin
        rggb_exp = '{8'h11, 8'h22, 8'h11, 8'h22, 8'h22, 8'h33, 8'h22, 8'h33};
        bus.Din_Valid = 1'b0;
        bus.Din_Sof   = 1'b0;
        bus.Din_Eol   = 1'b0;
        bus.RED       = 8'h11;
        bus.GREEN     = 8'h22;
        bus.BLUE      = 8'h33;
        bus.Pattern   = 2'd0;
        Rst_n         = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        chk_zero("reset");
        Rst_n = 1'b1;

        // Pixels before any Sof are dropped
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);

        // RGGB 4x2
        pix(1, 0, 8'h11); pix(0, 0, 8'h22); pix(0, 0, 8'h11); pix(0, 1, 8'h22);
        chk("rggb_line_len", 32'(bus.Line_Len), 32'd4);
        pix(0, 0, 8'h22); pix(0, 0, 8'h33); pix(0, 0, 8'h22); pix(0, 1, 8'h33);
        chk("rggb_len_err", 32'(bus.Len_Err), 32'd0);
        chk("rggb_frame_lines_first", 32'(bus.Frame_Lines), 32'd0);
        idle(2);
        chk("raw_hold", 32'(bus.RAW_Data), 32'h33);

        // GRBG, with a mid-frame Pattern change that must be ignored
        bus.Pattern = 2'd1;
        pix(1, 0, 8'h22);
        chk("grbg_frame_lines", 32'(bus.Frame_Lines), 32'd2);
        bus.Pattern = 2'd3;
        pix(0, 1, 8'h11);
        chk("grbg_line_len", 32'(bus.Line_Len), 32'd2);
        pix(0, 0, 8'h33); pix(0, 1, 8'h22);
        chk("grbg_len_err", 32'(bus.Len_Err), 32'd0);

        // GBRG
        bus.Pattern = 2'd2;
        pix(1, 0, 8'h22); pix(0, 1, 8'h33); pix(0, 0, 8'h11); pix(0, 1, 8'h22);

        // BGGR
        bus.Pattern = 2'd3;
        pix(1, 0, 8'h33);
        chk("bggr_frame_lines", 32'(bus.Frame_Lines), 32'd2);
        pix(0, 1, 8'h22); pix(0, 0, 8'h22); pix(0, 1, 8'h11);

        // RGGB 4x2 with random idle gaps
        bus.Pattern = 2'd0;
        for (int i = 0; i < 8; i++) begin
            idle(int'($urandom_range(0, 2)));
            pix(i == 0, (i == 3) || (i == 7), rggb_exp[i]);
        end
        chk("gap_line_len", 32'(bus.Line_Len), 32'd4);

        // Lines of 4, 4, 3
        pix(1, 0, 8'h11);
        chk("lenerr_frame_lines", 32'(bus.Frame_Lines), 32'd2);
        pix(0, 0, 8'h22); pix(0, 0, 8'h11); pix(0, 1, 8'h22);
        pix(0, 0, 8'h22); pix(0, 0, 8'h33); pix(0, 0, 8'h22); pix(0, 1, 8'h33);
        chk("lenerr_before", 32'(bus.Len_Err), 32'd0);
        pix(0, 0, 8'h11); pix(0, 0, 8'h22);
        chk("lenerr_mid_short", 32'(bus.Len_Err), 32'd0);
        pix(0, 1, 8'h11);
        chk("lenerr_rise", 32'(bus.Len_Err), 32'd1);
        idle(2);
        chk("lenerr_sticky", 32'(bus.Len_Err), 32'd1);

        // Sof clears Len_Err; then abort after 1.5 lines
        pix(1, 0, 8'h11);
        chk("lenerr_clear", 32'(bus.Len_Err), 32'd0);
        chk("lenerr_frame_lines3", 32'(bus.Frame_Lines), 32'd3);
        pix(0, 0, 8'h22); pix(0, 0, 8'h11); pix(0, 1, 8'h22);
        pix(0, 0, 8'h22); pix(0, 0, 8'h33);
        pix(1, 0, 8'h11);
        chk("abort_frame_lines", 32'(bus.Frame_Lines), 32'd1);
        chk("abort_line_len", 32'(bus.Line_Len), 32'd4);
        pix(0, 0, 8'h22);

        // Asynchronous reset mid-line
        #2;
        Rst_n = 1'b0;
        #1;
        chk_zero("async_rst");
        bus.Din_Valid = 1'b0;
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);

        // 1-pixel lines
        pix(1, 1, 8'h11);
        chk("px1_line_len", 32'(bus.Line_Len), 32'd1);
        chk("px1_frame_lines", 32'(bus.Frame_Lines), 32'd0);
        pix(0, 1, 8'h22); pix(0, 1, 8'h11);
        chk("px1_line_len_end", 32'(bus.Line_Len), 32'd1);
        chk("px1_len_err", 32'(bus.Len_Err), 32'd0);
        pix(1, 0, 8'h11);
        chk("px1_frame_lines3", 32'(bus.Frame_Lines), 32'd3);
        idle(1);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
